calc_arbiter: RTL and testbench
===============================

# calc_arbiter

- Round-robin arbiter and sequencer that shares one 4-bit `calculator` ALU among `N_REQ` requesters.
- Each requester offers an operation over a valid/ready handshake. The arbiter grants one request, latches its operands, drives the ALU, and returns a registered result tagged with the requester ID over a valid/ready response channel.
- Sits between client blocks and the single `calculator` instance, which it instantiates internally.

## Interface

Parameters:
- `N_REQ`, default 4: number of requesters, legal range 2..8.
- `ID_W`, default `$clog2(N_REQ)`: width of the requester ID. Derived; do not override.

Ports:
- `clk`  in  1: single clock; all logic on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req_valid`  in  N_REQ: bit i set means requester i has an operation pending.
- `req_ready`  out  N_REQ: one-hot grant; bit i set means requester i's operation is accepted this cycle.
- `req_a`  in  4*N_REQ: operand A; slice [4i+3:4i] belongs to requester i.
- `req_b`  in  4*N_REQ: operand B, same slicing.
- `req_op`  in  3*N_REQ: opcode; slice [3i+2:3i] belongs to requester i.
- `resp_valid`  out  1: a result is presented.
- `resp_ready`  in  1: the consumer accepts the result.
- `resp_result`  out  4: ALU result.
- `resp_id`  out  ID_W: index of the requester that issued the operation.
- `resp_err`  out  1: present only with `CALC_ARB_ILLEGAL_OP_EN` (see Configuration).

## Operation

ALU semantics (the arbiter adds no arithmetic of its own):
- 000: A+B mod 16.
- 001: A−B mod 16.
- 010: A&B.
- 011: A|B.
- 100: ~A.
- 101–111: result 0.

FSM states:
- IDLE
  - If any `req_valid` is set, select winner w by round-robin: search starts at `last_grant+1` and wraps modulo N_REQ.
  - Assert `req_ready[w]` combinationally in this cycle.
  - Latch `req_a`, `req_b`, `req_op` slices of w and set `id_q`=w, `last_grant`=w.
  - Go to EXEC.
  - If no request is pending, stay in IDLE with `req_ready`=0.
- EXEC
  - Latched operands drive the ALU.
  - On the clock edge: `resp_result`←ALU output, `resp_id`←`id_q`, `resp_valid`←1.
  - Go to RESP.
- RESP
  - Hold all `resp_*` stable while `resp_ready`=0.
  - On `resp_valid && resp_ready`: clear `resp_valid` and go to IDLE.

General rules:
- `req_ready` is 0 in EXEC and RESP. At most one bit of `req_ready` is set in any cycle.
- A request is committed only on `req_valid[i] && req_ready[i]`. A requester may drop or change an un-granted request freely.
- Operands are sampled only in the grant cycle; later changes on `req_*` have no effect on an accepted operation.

## Timing

Reset values (synchronous `rst`):
- State IDLE; `last_grant`=N_REQ−1, so requester 0 wins first.
- `resp_valid`=0, `resp_result`=0, `resp_id`=0, `req_ready`=0, `resp_err`=0.

Latency and throughput:
- Grant at cycle T gives `resp_valid`=1 at cycle T+2.
- With `resp_ready` held at 1, the next grant can occur at T+3, so peak throughput is one operation per 3 cycles.
- Each stall cycle with `resp_ready`=0 adds one cycle.

Boundary conditions:
- Simultaneous requests: exactly one grant per IDLE cycle, in round-robin order. Every continuously asserted requester is served within N_REQ grants.
- `rst` asserted in EXEC or RESP: the in-flight operation is discarded with no response, and no grant is issued in the reset cycle.
- `resp_ready` high while `resp_valid`=0: ignored.
- Single active requester: it is granted on every IDLE pass, with no idle gap beyond the FSM's 3-cycle loop.

## Configuration

Macro `CALC_ARB_ILLEGAL_OP_EN`:
- Defined:
  - Port `resp_err` exists.
  - It is registered alongside `resp_result` and is 1 when the latched opcode is 101–111.
  - `resp_result` is still 0 for those opcodes.
  - It is cleared on reset and holds stable in RESP.
- Undefined:
  - Port `resp_err` does not exist and no opcode decode is added.
  - Illegal opcodes silently return 0.

## Test plan

- **Single request, ADD.** After reset, `req_valid`=0001 with A=7, B=5, op=000 → `req_ready`=0001 in the same cycle. Two cycles later `resp_valid`=1, `resp_result`=12, `resp_id`=0.
- **Wrap and NOT.** Requester 2 issues A=3, B=5, op=001 → result 14 (wrap), id 2. Then A=4'b1010, op=100 → result 4'b0101.
- **Fairness under full load.** All four requesters valid continuously with `resp_ready`=1 → grant order 0,1,2,3,0; one grant every 3 cycles; `req_ready` always one-hot.
- **Response back-pressure.** `resp_ready`=0 for 5 cycles with an op=011 result (A=1100, B=0011 → 1111) → `resp_valid`, `resp_result`, `resp_id` stay stable, no new grant occurs, and the FSM returns to IDLE the cycle after `resp_ready`=1.
- **Reset in EXEC.** Pulse `rst` the cycle after a grant → `resp_valid` never rises, the next grant goes to requester 0, and outputs hold their reset values.
- **Illegal opcode.** op=110 with A=9, B=9 → `resp_result`=0. With the macro defined, `resp_err`=1; without it, the port is absent.

Source files
------------

// File: rtl/calc_arbiter.sv
// rtl/calc_arbiter.sv - round-robin arbiter sequencing N_REQ requesters onto one calculator ALU
// Define CALC_ARB_ILLEGAL_OP_EN to add the resp_err output flagging opcodes 101-111.
module calc_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [4*N_REQ-1:0]   req_a,
  input  logic [4*N_REQ-1:0]   req_b,
  input  logic [3*N_REQ-1:0]   req_op,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [3:0]           resp_result,
  output logic [ID_W-1:0]      resp_id
`ifdef CALC_ARB_ILLEGAL_OP_EN
  ,
  output logic                 resp_err
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_REQ - 1);

  state_t          state_q, state_d;
  logic [ID_W-1:0] last_grant_q, last_grant_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [3:0]      a_q, a_d;
  logic [3:0]      b_q, b_d;
  logic [2:0]      op_q, op_d;
  logic            resp_valid_q, resp_valid_d;
  logic [3:0]      resp_result_q, resp_result_d;
  logic [ID_W-1:0] resp_id_q, resp_id_d;

  logic            any_valid;
  logic [ID_W-1:0] win;
  logic [3:0]      sel_a, sel_b;
  logic [2:0]      sel_op;
  logic [3:0]      alu_result;
  int              idx;

  calculator u_calc (
    .a      (a_q),
    .b      (b_q),
    .op     (op_q),
    .result (alu_result)
  );

  // Search starts just past the last winner so every pending requester is
  // reached within N_REQ grants.
  always_comb begin
    any_valid = 1'b0;
    win       = '0;
    sel_a     = '0;
    sel_b     = '0;
    sel_op    = '0;
    idx       = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(last_grant_q) + k) % N_REQ;
      if (!any_valid && req_valid[idx]) begin
        any_valid = 1'b1;
        win       = ID_W'(idx);
        sel_a     = req_a[4*idx +: 4];
        sel_b     = req_b[4*idx +: 4];
        sel_op    = req_op[3*idx +: 3];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    id_d          = id_q;
    a_d           = a_q;
    b_d           = b_q;
    op_d          = op_q;
    resp_valid_d  = resp_valid_q;
    resp_result_d = resp_result_q;
    resp_id_d     = resp_id_q;
    req_ready     = '0;
    case (state_q)
      S_IDLE: begin
        if (any_valid && !rst) begin
          req_ready    = N_REQ'(1) << win;
          a_d          = sel_a;
          b_d          = sel_b;
          op_d         = sel_op;
          id_d         = win;
          last_grant_d = win;
          state_d      = S_EXEC;
        end
      end
      S_EXEC: begin
        resp_result_d = alu_result;
        resp_id_d     = id_q;
        resp_valid_d  = 1'b1;
        state_d       = S_RESP;
      end
      S_RESP: begin
        if (resp_valid_q && resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      last_grant_q  <= LAST_ID;
      id_q          <= '0;
      a_q           <= '0;
      b_q           <= '0;
      op_q          <= '0;
      resp_valid_q  <= 1'b0;
      resp_result_q <= '0;
      resp_id_q     <= '0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      id_q          <= id_d;
      a_q           <= a_d;
      b_q           <= b_d;
      op_q          <= op_d;
      resp_valid_q  <= resp_valid_d;
      resp_result_q <= resp_result_d;
      resp_id_q     <= resp_id_d;
    end
  end

  assign resp_valid  = resp_valid_q;
  assign resp_result = resp_result_q;
  assign resp_id     = resp_id_q;

`ifdef CALC_ARB_ILLEGAL_OP_EN
  logic resp_err_q, resp_err_d;

  always_comb begin
    resp_err_d = resp_err_q;
    if (state_q == S_EXEC) begin
      resp_err_d = op_q[2] & (op_q[1] | op_q[0]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_err_q <= 1'b0;
    end else begin
      resp_err_q <= resp_err_d;
    end
  end

  assign resp_err = resp_err_q;
`endif

endmodule

// Shared 4-bit ALU; unused opcodes return zero.
module calculator (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [2:0] op,
  output logic [3:0] result
);

  always_comb begin
    result = '0;
    case (op)
      3'b000:  result = a + b;
      3'b001:  result = a - b;
      3'b010:  result = a & b;
      3'b011:  result = a | b;
      3'b100:  result = ~a;
      default: result = '0;
    endcase
  end

endmodule

// File: tb/tb_calc_arbiter.sv
// tb/tb_calc_arbiter.sv - directed self-checking bench for calc_arbiter
module tb_calc_arbiter;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  logic [4*N-1:0] req_a;
  logic [4*N-1:0] req_b;
  logic [3*N-1:0] req_op;
  logic          resp_valid;
  logic          resp_ready;
  logic [3:0]    resp_result;
  logic [1:0]    resp_id;
`ifdef CALC_ARB_ILLEGAL_OP_EN
  logic          resp_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  calc_arbiter #(.N_REQ(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_op      (req_op),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_result (resp_result),
    .resp_id     (resp_id)
`ifdef CALC_ARB_ILLEGAL_OP_EN
    ,
    .resp_err    (resp_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    req_a[4*i +: 4]  = a;
    req_b[4*i +: 4]  = b;
    req_op[3*i +: 3] = op;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic check_err(input string tag, input logic exp_err);
`ifdef CALC_ARB_ILLEGAL_OP_EN
    check({tag, "_err"}, resp_err, exp_err);
`else
    if (exp_err === 1'bx) check({tag, "_err"}, 0, 1);
`endif
  endtask

  // Single-requester operation with resp_ready held high.
  task automatic do_op(input string tag, input int i, input logic [3:0] a, input logic [3:0] b,
                       input logic [2:0] op, input logic [3:0] exp_res, input logic exp_err);
    set_req(i, a, b, op);
    req_valid  = 4'b0001 << i;
    resp_ready = 1'b1;
    #1;
    check({tag, "_grant"}, req_ready, 4'b0001 << i);
    tick();
    req_valid = '0;
    set_req(i, ~a, ~b, 3'b000);
    #1;
    check({tag, "_exec_ready"}, req_ready, 0);
    check({tag, "_exec_valid"}, resp_valid, 0);
    tick();
    check({tag, "_valid"}, resp_valid, 1);
    check({tag, "_result"}, resp_result, exp_res);
    check({tag, "_id"}, resp_id, i);
    check_err(tag, exp_err);
    tick();
    check({tag, "_done"}, resp_valid, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int order [5];
    order      = '{0, 1, 2, 3, 0};
    rst        = 1'b1;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    req_op     = '0;
    resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rst_valid", resp_valid, 0);
    check("rst_result", resp_result, 0);
    check("rst_id", resp_id, 0);
    check("rst_ready", req_ready, 0);
    check_err("rst", 1'b0);

    do_op("add", 0, 4'd7, 4'd5, 3'b000, 4'd12, 1'b0);
    do_op("sub", 2, 4'd3, 4'd5, 3'b001, 4'd14, 1'b0);
    do_op("not", 2, 4'b1010, 4'd0, 3'b100, 4'b0101, 1'b0);

    // Full load from reset: order 0,1,2,3,0 with one grant every 3 cycles.
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 4'(i), 4'd1, 3'b000);
    req_valid  = 4'hF;
    resp_ready = 1'b1;
    #1;
    for (int g = 0; g < 5; g++) begin
      check("fair_grant", req_ready, 4'b0001 << order[g]);
      check("fair_onehot", $onehot(req_ready), 1);
      tick();
      check("fair_exec_ready", req_ready, 0);
      tick();
      check("fair_valid", resp_valid, 1);
      check("fair_id", resp_id, order[g]);
      check("fair_result", resp_result, order[g] + 1);
      check("fair_resp_ready", req_ready, 0);
      tick();
    end
    req_valid = '0;

    // Back-pressure: OR result held for 5 stall cycles while requester 3 waits.
    set_req(1, 4'b1100, 4'b0011, 3'b011);
    set_req(3, 4'd2, 4'd3, 3'b000);
    resp_ready = 1'b0;
    req_valid  = 4'b0010;
    #1;
    check("bp_grant", req_ready, 4'b0010);
    tick();
    req_valid = 4'b1000;
    tick();
    check("bp_valid", resp_valid, 1);
    for (int s = 0; s < 5; s++) begin
      tick();
      check("bp_hold_valid", resp_valid, 1);
      check("bp_hold_result", resp_result, 4'b1111);
      check("bp_hold_id", resp_id, 1);
      check("bp_no_grant", req_ready, 0);
    end
    resp_ready = 1'b1;
    tick();
    check("bp_release_valid", resp_valid, 0);
    check("bp_next_grant", req_ready, 4'b1000);
    tick();
    req_valid = '0;
    tick();
    check("bp_next_result", resp_result, 4'd5);
    check("bp_next_id", resp_id, 3);
    tick();

    // Reset while in EXEC: operation dropped, round robin restarts at 0.
    set_req(2, 4'd1, 4'd1, 3'b000);
    req_valid = 4'b0100;
    #1;
    check("rexec_grant", req_ready, 4'b0100);
    tick();
    rst = 1'b1;
    #1;
    check("rexec_rst_ready", req_ready, 0);
    tick();
    rst       = 1'b0;
    req_valid = '0;
    check("rexec_valid0", resp_valid, 0);
    check("rexec_result0", resp_result, 0);
    check("rexec_id0", resp_id, 0);
    tick();
    check("rexec_valid1", resp_valid, 0);
    tick();
    check("rexec_valid2", resp_valid, 0);
    set_req(0, 4'd5, 4'd6, 3'b010);
    set_req(3, 4'd9, 4'd9, 3'b000);
    req_valid = 4'b1001;
    #1;
    check("rexec_regrant", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    tick();
    check("rexec_and_result", resp_result, 4'd4);
    check("rexec_and_id", resp_id, 0);
    tick();

    do_op("ill110", 1, 4'd9, 4'd9, 3'b110, 4'd0, 1'b1);
    do_op("ill101", 3, 4'd9, 4'd9, 3'b101, 4'd0, 1'b1);
    do_op("or_after", 0, 4'b0101, 4'b1000, 3'b011, 4'b1101, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
